fetch_sequencer: RTL

//  Owns the architectural fetch PC and runs the instruction-memory request/ready handshake.

---
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready handshake between the fetch sequencer and imem.
interface fetch_sequencer_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, runs one-outstanding imem requests and
// buffers returned words in a 2-entry queue feeding IF/ID.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    fetch_sequencer_if.master   imem,
    output logic                if_valid,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_instr,
    output logic [31:0]         fetch_pc
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {BOOT, IDLE, BUSY, KILL} state_e;

    state_e          state_q;
    logic [CW-1:0]   count_q;
    logic            valid_q;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_q    [2];
    logic [XLEN-1:0] instr_q [2];

    logic            pop_d;
    logic            push_d;
    logic            issue_d;
    logic            tail_d;
    logic [CW-1:0]   count_d;
    logic [XLEN-1:0] redirect_pc_d;

    // Queue occupancy after this cycle and whether a new request may go out next cycle.
    always_comb begin
        pop_d         = valid_q & ~stall;
        push_d        = (state_q == BUSY) & imem.imem_ready & ~redirect_valid;
        count_d       = count_q - CW'(pop_d) + CW'(push_d);
        tail_d        = (count_d == CW'(2));
        issue_d       = (count_d <= CW'(1)) & ~redirect_valid & (state_q != BOOT);
        redirect_pc_d = redirect_target & ~XLEN'(3);
    end

    // Handshake FSM, fetch PC and queue; redirect overrides stall, push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            count_q    <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
        end else if (redirect_valid) begin
            count_q    <= '0;
            valid_q    <= 1'b0;
            fetch_pc_q <= redirect_pc_d;
            // An un-answered request cannot be withdrawn; wait it out in KILL.
            if ((state_q == BUSY || state_q == KILL) && !imem.imem_ready) begin
                state_q <= KILL;
            end else begin
                state_q <= IDLE;
                req_q   <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= (count_d != '0);
            // Slot 0 is the head; it only advances when a second entry exists,
            // so an emptied queue keeps showing the last popped word.
            if (pop_d && count_q == CW'(2)) begin
                pc_q[0]    <= pc_q[1];
                instr_q[0] <= instr_q[1];
            end
            if (push_d) begin
                pc_q[tail_d]    <= fetch_pc_q;
                instr_q[tail_d] <= imem.imem_rdata;
                fetch_pc_q      <= fetch_pc_q + XLEN'(4);
            end
            case (state_q)
                BOOT: state_q <= IDLE;
                IDLE: begin
                    if (issue_d) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                BUSY: begin
                    if (imem.imem_ready) begin
                        if (issue_d) begin
                            addr_q <= fetch_pc_q + XLEN'(4);
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                KILL: begin
                    if (imem.imem_ready) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_valid       = valid_q;
    assign if_pc          = pc_q[0];
    assign if_instr       = instr_q[0];
    assign fetch_pc       = fetch_pc_q;
endmodule
